inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 150 +++++++++++++++
 tb/tb_inst_encoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// MIPS-style instruction encoder: latches a request, builds the 32-bit word, writes it to instruction memory.
// Accept-to-mem_write is 2 cycles; req_ready is low from accept until mem_ack retires the write.
module inst_encoder (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_mnem,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [15:0] req_imm,
  input  logic [25:0] req_index,
  input  logic        base_load,
  input  logic [31:0] base_addr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_write,
  input  logic        mem_ack,
  output logic        err,
  output logic [15:0] word_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    WR   = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  lat_mnem, lat_rs, lat_rt, lat_rd;
  logic [15:0] lat_imm;
  logic [25:0] lat_index;
  logic [31:0] word;
  logic [5:0]  fn, op;
  logic [4:0]  rt_eff, rd_eff;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_addr   <= 32'h0;
      mem_data   <= 32'h0;
      word_count <= 16'h0;
      lat_mnem   <= 5'h0;
      lat_rs     <= 5'h0;
      lat_rt     <= 5'h0;
      lat_rd     <= 5'h0;
      lat_imm    <= 16'h0;
      lat_index  <= 26'h0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // Pointer preset lands before the accepted word is written, so that word goes to base_addr.
          if (base_load) mem_addr <= base_addr & 32'hFFFF_FFFC;
          if (req_valid) begin
            lat_mnem  <= req_mnem;
            lat_rs    <= req_rs;
            lat_rt    <= req_rt;
            lat_rd    <= req_rd;
            lat_imm   <= req_imm;
            lat_index <= req_index;
          end
        end
        ENC: mem_data <= word;
        WR: begin
          if (mem_ack) begin
            mem_addr   <= mem_addr + 32'd4;
            word_count <= word_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_write = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (req_mnem <= 5'd23) ? ENC : ERR;
      end
      ENC: state_nxt = WR;
      WR: begin
        mem_write = 1'b1;
        if (mem_ack) state_nxt = IDLE;
      end
      ERR: begin
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fn = 6'b000000;
    op = 6'b000000;
    case (lat_mnem)
      5'd0:  fn = 6'b000100;
      5'd1:  fn = 6'b000110;
      5'd2:  fn = 6'b000111;
      5'd3:  fn = 6'b001000;
      5'd4:  fn = 6'b100000;
      5'd5:  fn = 6'b100001;
      5'd6:  fn = 6'b100010;
      5'd7:  fn = 6'b100011;
      5'd8:  fn = 6'b100100;
      5'd9:  fn = 6'b100101;
      5'd10: fn = 6'b100110;
      5'd11: fn = 6'b100111;
      5'd12: op = 6'b000010;
      5'd13: op = 6'b000100;
      5'd14: op = 6'b000101;
      5'd15: op = 6'b000110;
      5'd16: op = 6'b000111;
      5'd17: op = 6'b001000;
      5'd18: op = 6'b001001;
      5'd19: op = 6'b001100;
      5'd20: op = 6'b001101;
      5'd21: op = 6'b001110;
      5'd22: op = 6'b100011;
      5'd23: op = 6'b101011;
      default: ;
    endcase
  end

  always_comb begin
    rt_eff = lat_rt;
    rd_eff = lat_rd;
    if (lat_mnem == 5'd3) begin
      rt_eff = 5'd0;
      rd_eff = 5'd0;
    end
    if (lat_mnem == 5'd15 || lat_mnem == 5'd16) rt_eff = 5'd0;

    if (lat_mnem <= 5'd11)
      word = {6'b000000, lat_rs, rt_eff, rd_eff, 5'b00000, fn};
    else if (lat_mnem == 5'd12)
      word = {op, lat_index};
    else
      word = {op, lat_rs, rt_eff, lat_imm};
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed and random checks of inst_encoder against an arithmetic reference model.
module tb_inst_encoder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_mnem = '0, req_rs = '0, req_rt = '0, req_rd = '0;
  logic [15:0] req_imm = '0;
  logic [25:0] req_index = '0;
  logic        base_load = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] mem_addr, mem_data;
  logic        mem_write;
  logic        mem_ack = 1'b0;
  logic        err;
  logic [15:0] word_count;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_addr = 0;
  int unsigned exp_count = 0;
  logic [31:0] seen_addr, seen_data;
  int unsigned fn_tab[12] = '{4, 6, 7, 8, 32, 33, 34, 35, 36, 37, 38, 39};
  int unsigned op_tab[11] = '{4, 5, 6, 7, 8, 9, 12, 13, 14, 35, 43};

  inst_encoder dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_mnem(req_mnem), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_imm(req_imm), .req_index(req_index), .base_load(base_load), .base_addr(base_addr),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write), .mem_ack(mem_ack),
    .err(err), .word_count(word_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_word(input int m, input int rs, input int rt,
                                             input int rd, input int imm, input int idx);
    longint unsigned w;
    if (m <= 11) begin
      if (m == 3) begin rt = 0; rd = 0; end
      w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + fn_tab[m];
    end else if (m == 12) begin
      w = 2 * 67108864 + longint'(idx);
    end else begin
      if (m == 15 || m == 16) rt = 0;
      w = longint'(op_tab[m-13]) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
    end
    return w[31:0];
  endfunction

  // Presents one request and follows it to the first WR cycle (or through ERR for bad mnemonics).
  task automatic start_req(input int m, input int rs, input int rt, input int rd, input int imm,
                           input int idx, input bit bl, input logic [31:0] ba, output bit in_wr);
    logic [31:0] expw;
    logic [4:0]  m5;
    int          r;
    expw = model_word((m > 23) ? 0 : m, rs, rt, rd, imm, idx);
    @(negedge clock);
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    m5 = m[4:0];
    req_valid = 1'b1; req_mnem = m5;
    req_rs = rs[4:0]; req_rt = rt[4:0]; req_rd = rd[4:0];
    req_imm = imm[15:0]; req_index = idx[25:0];
    base_load = bl; base_addr = ba;
    if (bl) exp_addr = ba & 32'hFFFF_FFFC;
    @(posedge clock); #1;
    req_valid = 1'b0; base_load = 1'b0;
    r = $urandom; req_rs = r[4:0]; req_rt = r[9:5]; req_rd = r[14:10]; req_imm = r[31:16];
    r = $urandom; req_index = r[25:0]; req_mnem = r[30:26];
    @(negedge clock);
    chk("ready_busy", {31'b0, req_ready}, 32'd0);
    if (m > 23) begin
      chk("err_pulse", {31'b0, err}, 32'd1);
      chk("err_nowrite", {31'b0, mem_write}, 32'd0);
      @(negedge clock);
      chk("err_drop", {31'b0, err}, 32'd0);
      chk("err_ready", {31'b0, req_ready}, 32'd1);
      chk("err_count", {16'b0, word_count}, exp_count);
      chk("err_addr", mem_addr, exp_addr);
      in_wr = 1'b0;
    end else begin
      chk("enc_nowrite", {31'b0, mem_write}, 32'd0);
      @(negedge clock);
      chk("wr_write", {31'b0, mem_write}, 32'd1);
      chk("wr_addr", mem_addr, exp_addr);
      chk("wr_data", mem_data, expw);
      seen_addr = mem_addr;
      seen_data = mem_data;
      in_wr = 1'b1;
    end
  endtask

  task automatic finish_ack(input int dly);
    logic [31:0] r;
    for (int i = 0; i < dly; i++) begin
      // A preset during WR must not disturb the pointer.
      r = $urandom;
      base_load = (i == 0); base_addr = r;
      @(negedge clock);
      chk("hold_write", {31'b0, mem_write}, 32'd1);
      chk("hold_addr", mem_addr, seen_addr);
      chk("hold_data", mem_data, seen_data);
      chk("hold_ready", {31'b0, req_ready}, 32'd0);
    end
    base_load = 1'b0;
    mem_ack = 1'b1;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    exp_addr = exp_addr + 32'd4;
    exp_count = (exp_count + 1) % 65536;
    @(negedge clock);
    chk("post_write", {31'b0, mem_write}, 32'd0);
    chk("post_ready", {31'b0, req_ready}, 32'd1);
    chk("post_addr", mem_addr, exp_addr);
    chk("post_count", {16'b0, word_count}, exp_count);
  endtask

  task automatic send(input int m, input int rs, input int rt, input int rd, input int imm,
                      input int idx, input int dly, input bit bl, input logic [31:0] ba);
    bit in_wr;
    start_req(m, rs, rt, rd, imm, idx, bl, ba, in_wr);
    if (in_wr) finish_ack(dly);
  endtask

  initial begin
    bit in_wr;
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_write", {31'b0, mem_write}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", mem_data, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_count", {16'b0, word_count}, 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    send(4, 1, 2, 3, 16'h1234, 0, 0, 1'b0, 32'h0);
    chk("add_word", seen_data, 32'h0022_1820);
    chk("add_addr", seen_addr, 32'h0);

    send(22, 29, 8, 5, 16'h0010, 0, 0, 1'b1, 32'h0040_0000);
    chk("lw_word", seen_data, 32'h8FA8_0010);
    chk("lw_addr", seen_addr, 32'h0040_0000);

    send(15, 4, 7, 9, 16'hFFFF, 0, 1, 1'b0, 32'h0);
    chk("blez_word", seen_data, 32'h1880_FFFF);
    send(12, 31, 31, 31, 16'hFFFF, 26'h010_0000, 0, 1'b0, 32'h0);
    chk("j_word", seen_data, 32'h0810_0000);
    send(3, 7, 9, 11, 16'hABCD, 0, 0, 1'b0, 32'h0);

    send(27, 1, 2, 3, 4, 5, 0, 1'b0, 32'h0);
    send(10, 12, 13, 14, 0, 0, 5, 1'b0, 32'h0);

    send(23, 1, 2, 3, 16'h8000, 0, 0, 1'b1, 32'hFFFF_FFFF);
    chk("wrap_addr0", seen_addr, 32'hFFFF_FFFC);
    send(0, 1, 2, 3, 0, 0, 0, 1'b0, 32'h0);
    chk("wrap_addr1", seen_addr, 32'h0);

    @(negedge clock);
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    chk("idle_ack_addr", mem_addr, exp_addr);
    chk("idle_ack_count", {16'b0, word_count}, exp_count);
    chk("idle_ack_write", {31'b0, mem_write}, 32'd0);

    start_req(6, 3, 4, 5, 0, 0, 1'b0, 32'h0, in_wr);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_write", {31'b0, mem_write}, 32'd0);
    chk("abort_addr", mem_addr, 32'd0);
    chk("abort_data", mem_data, 32'd0);
    chk("abort_count", {16'b0, word_count}, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_err", {31'b0, err}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_addr = 0;
    exp_count = 0;

    for (int n = 0; n < 80; n++) begin
      int m;
      bit bl;
      m  = ($urandom_range(0, 9) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
      bl = ($urandom_range(0, 7) == 0);
      send(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 65535), $urandom_range(0, 67108863), $urandom_range(0, 3),
           bl, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
